// File: rtl/pipelined_adder_subtractor_pkg.sv
// Shared constants and elaboration helpers for the chunked adder/subtractor.
package pipelined_adder_subtractor_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Width must tile exactly into whole chunks, one chunk per stage.
   function automatic bit width_is_valid(input int data_width, input int chunk_width);
      return (chunk_width > 0) && (data_width >= chunk_width) &&
             ((data_width % chunk_width) == 0);
   endfunction

endpackage

// File: rtl/pipelined_adder_subtractor_if.sv
// Operand/result bus of the pipelined adder/subtractor.
interface pipelined_adder_subtractor_if #(
   parameter int DATA_WIDTH = 16
);
   // Handshake: a beat moves on a side only in a cycle where its VALID and
   // READY are both high at the rising edge; a producer holding VALID keeps
   // its data stable until that edge, and VALID never waits on READY.
   logic                  IN_VALID;
   logic                  IN_READY;
   logic                  MODE;
   logic [DATA_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] B;
   logic                  Cin;
   logic                  OUT_VALID;
   logic                  OUT_READY;
   logic [DATA_WIDTH-1:0] S;
   logic                  CF;
   logic                  OF;
   logic                  ZF;
   logic                  NF;

   modport master (
      output IN_VALID, MODE, A, B, Cin, OUT_READY,
      input  IN_READY, OUT_VALID, S, CF, OF, ZF, NF
   );

   modport slave (
      input  IN_VALID, MODE, A, B, Cin, OUT_READY,
      output IN_READY, OUT_VALID, S, CF, OF, ZF, NF
   );

endinterface

// File: rtl/pipelined_adder_subtractor_chunk.sv
// Ripple-carry slice used by each pipeline stage, built from full_adder cells.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);
   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module adder_chunk #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_s,
   output logic             o_cout,
   output logic             o_cmsb
);
   logic [WIDTH:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .i_a    (i_a[i]),
         .i_b    (i_b[i]),
         .i_cin  (w_c[i]),
         .o_s    (o_s[i]),
         .o_cout (w_c[i+1])
      );
   end

   // Carry into the slice MSB; the top slice uses it for signed overflow.
   assign o_cmsb = w_c[WIDTH-1];
   assign o_cout = w_c[WIDTH];
endmodule

// File: rtl/pipelined_adder_subtractor.sv
// Pipelined two's-complement adder/subtractor: one CHUNK_WIDTH carry slice per
// stage, whole-pipe stall on output back-pressure, registered S/CF/OF/ZF/NF.
module pipelined_adder_subtractor
   import pipelined_adder_subtractor_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int CHUNK_WIDTH    = 4,
   parameter int OVERFLOW_LOGIC = 1
) (
   input  logic CLK,
   input  logic RST,
   pipelined_adder_subtractor_if.slave bus
);
   localparam int NUM_STAGES = DATA_WIDTH / CHUNK_WIDTH;
   localparam bit OVF_EN     = (OVERFLOW_LOGIC != 0) && (DATA_WIDTH > 1);

   if (!width_is_valid(DATA_WIDTH, CHUNK_WIDTH)) begin : g_width_check
      $error("DATA_WIDTH must be a non-zero multiple of CHUNK_WIDTH");
   end

   logic                  w_advance;
   logic                  w_sub_in;
   logic [DATA_WIDTH-1:0] w_b_in;

   // Subtraction is A + ~B + ~Cin; the inversions happen once, at entry.
   assign w_sub_in = (bus.MODE == MODE_SUB);
   assign w_b_in   = w_sub_in ? ~bus.B : bus.B;

   // The pipe moves as a unit whenever the output slot is empty or draining.
   assign w_advance    = bus.OUT_READY | ~g_stage[NUM_STAGES-1].r_v;
   assign bus.IN_READY = w_advance;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      localparam int HI = DATA_WIDTH - k * CHUNK_WIDTH;
      localparam int SW = (k + 1) * CHUNK_WIDTH;

      logic [HI-1:0]          w_opa;
      logic [HI-1:0]          w_opb;
      logic                   w_cin;
      logic                   w_mode;
      logic                   w_vin;
      logic                   w_load;
      logic [CHUNK_WIDTH-1:0] w_sum;
      logic                   w_cout;
      logic                   w_cmsb;
      logic [SW-1:0]          w_s_next;
      logic [SW-1:0]          r_s;
      logic                   r_v;

      if (k == 0) begin : g_src
         assign w_opa    = bus.A;
         assign w_opb    = w_b_in;
         assign w_cin    = bus.Cin ^ w_sub_in;
         assign w_mode   = w_sub_in;
         assign w_vin    = bus.IN_VALID;
         assign w_load   = w_advance & bus.IN_VALID;
         assign w_s_next = w_sum;
      end else begin : g_src
         assign w_opa    = g_stage[k-1].g_op.r_a;
         assign w_opb    = g_stage[k-1].g_op.r_b;
         assign w_cin    = g_stage[k-1].g_op.r_c;
         assign w_mode   = g_stage[k-1].g_op.r_mode;
         assign w_vin    = g_stage[k-1].r_v;
         assign w_load   = w_advance;
         assign w_s_next = {w_sum, g_stage[k-1].r_s};
      end

      adder_chunk #(
         .WIDTH (CHUNK_WIDTH)
      ) u_chunk (
         .i_a    (w_opa[CHUNK_WIDTH-1:0]),
         .i_b    (w_opb[CHUNK_WIDTH-1:0]),
         .i_cin  (w_cin),
         .o_s    (w_sum),
         .o_cout (w_cout),
         .o_cmsb (w_cmsb)
      );

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            r_v <= 1'b0;
         end else if (w_advance) begin
            r_v <= w_vin;
         end
      end

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            r_s <= '0;
         end else if (w_load) begin
            r_s <= w_s_next;
         end
      end

      if (k < NUM_STAGES - 1) begin : g_op
         // Operand bits not yet resolved ride along, shifted down one chunk.
         logic [HI-CHUNK_WIDTH-1:0] r_a;
         logic [HI-CHUNK_WIDTH-1:0] r_b;
         logic                      r_c;
         logic                      r_mode;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               r_a    <= '0;
               r_b    <= '0;
               r_c    <= 1'b0;
               r_mode <= 1'b0;
            end else if (w_load) begin
               r_a    <= w_opa[HI-1:CHUNK_WIDTH];
               r_b    <= w_opb[HI-1:CHUNK_WIDTH];
               r_c    <= w_cout;
               r_mode <= w_mode;
            end
         end
      end else begin : g_last
         logic r_cf;
         logic r_of;
         logic r_zf;
         logic r_nf;

         // CF reports borrow when subtracting, hence the inversion by mode.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               r_cf <= 1'b0;
               r_of <= 1'b0;
               r_zf <= 1'b0;
               r_nf <= 1'b0;
            end else if (w_load) begin
               r_cf <= w_cout ^ w_mode;
               r_of <= OVF_EN & (w_cmsb ^ w_cout);
               r_zf <= ~|w_s_next;
               r_nf <= w_s_next[SW-1];
            end
         end
      end
   end

   assign bus.OUT_VALID = g_stage[NUM_STAGES-1].r_v;
   assign bus.S         = g_stage[NUM_STAGES-1].r_s;
   assign bus.CF        = g_stage[NUM_STAGES-1].g_last.r_cf;
   assign bus.OF        = g_stage[NUM_STAGES-1].g_last.r_of;
   assign bus.ZF        = g_stage[NUM_STAGES-1].g_last.r_zf;
   assign bus.NF        = g_stage[NUM_STAGES-1].g_last.r_nf;

endmodule
